// File: rtl/i2c_reg_xfer_seq.sv
// Wishbone master that runs one single-byte I2C register write or read (repeated start)
// on an EF_I2C slave: clear status, load DATA/CMD, poll for completion, return data and error code.
module i2c_reg_xfer_seq #(
   parameter logic [31:0] BASE       = 32'h0000_0000,
   parameter logic [15:0] STATUS_OFF = 16'h0000,
   parameter logic [15:0] CMD_OFF    = 16'h0004,
   parameter logic [15:0] DATA_OFF   = 16'h0006,
   parameter int          POLL_LIMIT = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_rnw,
   input  logic [6:0]  req_dev,
   input  logic [7:0]  req_reg,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic [1:0]  rsp_err,
   output logic [31:0] m_adr_o,
   output logic [31:0] m_dat_o,
   input  logic [31:0] m_dat_i,
   output logic [3:0]  m_sel_o,
   output logic        m_we_o,
   output logic        m_cyc_o,
   output logic        m_stb_o,
   input  logic        m_ack_i
);
   localparam int            CW      = $clog2(POLL_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(POLL_LIMIT);

   typedef enum logic [3:0] {
      S_IDLE, S_CLR, S_WDAT0, S_WDAT1, S_WCMD, S_RCMD, S_PDATA, S_PSTAT, S_RESP
   } state_t;

   state_t        state_q, state_d;
   logic          rnw_q, rnw_d;
   logic [6:0]    dev_q, dev_d;
   logic [7:0]    reg_q, reg_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
   logic          phase_q, phase_d;
   logic          cyc_q, cyc_d, we_q, we_d;
   logic [3:0]    sel_q, sel_d;
   logic [31:0]   adr_q, adr_d;
   logic [15:0]   dat_q, dat_d;
   logic          ready_q, ready_d, rsp_valid_q, rsp_valid_d;
   logic [7:0]    rsp_rdata_q, rsp_rdata_d;
   logic [1:0]    rsp_err_q, rsp_err_d, fin_err_s;
   logic          ack_s, acc_en_s, acc_we_s, go_resp_s;
   logic [15:0]   acc_off_s, acc_dat_s;
   logic          unused_s;

   assign unused_s  = ^m_dat_i[31:9];
   assign ack_s     = cyc_q & m_ack_i;
   assign cnt_inc_s = cnt_q + CW'(1);

   // Next-state, request latching, poll evaluation and Wishbone access launch
   always_comb begin
      state_d     = state_q;
      rnw_d       = rnw_q;
      dev_d       = dev_q;
      reg_d       = reg_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      cnt_d       = cnt_q;
      phase_d     = phase_q;
      cyc_d       = cyc_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      we_d        = we_q;
      ready_d     = ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      acc_en_s    = 1'b0;
      acc_we_s    = 1'b0;
      acc_off_s   = STATUS_OFF;
      acc_dat_s   = 16'h0000;
      go_resp_s   = 1'b0;
      fin_err_s   = 2'd0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               rnw_d   = req_rnw;
               dev_d   = req_dev;
               reg_d   = req_reg;
               wdata_d = req_wdata;
               rdata_d = 8'h00;
               ready_d = 1'b0;
               state_d = S_CLR;
            end else begin
               ready_d = 1'b1;
            end
         end
         S_CLR: begin
            acc_en_s  = 1'b1;
            acc_we_s  = 1'b1;
            acc_dat_s = 16'h0008;
            if (ack_s) state_d = S_WDAT0;
            else       state_d = state_q;
         end
         S_WDAT0: begin
            acc_en_s  = 1'b1;
            acc_we_s  = 1'b1;
            acc_off_s = DATA_OFF;
            acc_dat_s = {6'd0, rnw_q, 1'b0, reg_q};
            if (ack_s) state_d = rnw_q ? S_WCMD : S_WDAT1;
            else       state_d = state_q;
         end
         S_WDAT1: begin
            acc_en_s  = 1'b1;
            acc_we_s  = 1'b1;
            acc_off_s = DATA_OFF;
            acc_dat_s = {6'd0, 1'b1, 1'b0, wdata_q};
            if (ack_s) state_d = S_WCMD;
            else       state_d = state_q;
         end
         S_WCMD: begin
            // A read keeps the bus (no stop) so the following read command is a repeated start
            acc_en_s  = 1'b1;
            acc_we_s  = 1'b1;
            acc_off_s = CMD_OFF;
            acc_dat_s = {3'b000, ~rnw_q, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, dev_q};
            if (ack_s) begin
               cnt_d   = {CW{1'b0}};
               phase_d = 1'b0;
               state_d = rnw_q ? S_RCMD : S_PSTAT;
            end else begin
               state_d = state_q;
            end
         end
         S_RCMD: begin
            acc_en_s  = 1'b1;
            acc_we_s  = 1'b1;
            acc_off_s = CMD_OFF;
            acc_dat_s = {3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, dev_q};
            if (ack_s) begin
               cnt_d   = {CW{1'b0}};
               phase_d = 1'b0;
               state_d = S_PDATA;
            end else begin
               state_d = state_q;
            end
         end
         S_PDATA: begin
            // Alternate DATA and STATUS reads so a NACKed read cannot hang waiting for valid
            acc_en_s  = 1'b1;
            acc_off_s = phase_q ? STATUS_OFF : DATA_OFF;
            if (ack_s) begin
               cnt_d   = cnt_inc_s;
               phase_d = ~phase_q;
               if (!phase_q && m_dat_i[8]) begin
                  rdata_d = m_dat_i[7:0];
                  cnt_d   = {CW{1'b0}};
                  phase_d = 1'b0;
                  state_d = S_PSTAT;
               end else if (phase_q && !m_dat_i[0] && m_dat_i[3]) begin
                  go_resp_s = 1'b1;
                  fin_err_s = 2'd1;
               end else if (cnt_inc_s >= LIMIT_C) begin
                  go_resp_s = 1'b1;
                  fin_err_s = 2'd2;
               end else begin
                  state_d = state_q;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_PSTAT: begin
            acc_en_s  = 1'b1;
            acc_off_s = STATUS_OFF;
            if (ack_s) begin
               cnt_d = cnt_inc_s;
               if (!m_dat_i[0]) begin
                  go_resp_s = 1'b1;
                  fin_err_s = m_dat_i[3] ? 2'd1 : 2'd0;
               end else if (cnt_inc_s >= LIMIT_C) begin
                  go_resp_s = 1'b1;
                  fin_err_s = 2'd2;
               end else begin
                  state_d = state_q;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (go_resp_s) begin
         state_d     = S_RESP;
         rsp_valid_d = 1'b1;
         rsp_err_d   = fin_err_s;
         rsp_rdata_d = (fin_err_s == 2'd0) ? rdata_q : 8'h00;
      end else begin
         rsp_valid_d = 1'b0;
      end

      // A fresh access only starts from an idle bus, which forces one dead cycle after each ack
      if (acc_en_s && !cyc_q) begin
         cyc_d = 1'b1;
         sel_d = 4'b0011;
         adr_d = BASE + {16'h0000, acc_off_s};
         dat_d = acc_dat_s;
         we_d  = acc_we_s;
      end else if (ack_s) begin
         cyc_d = 1'b0;
         sel_d = 4'b0000;
      end else begin
         cyc_d = cyc_q;
      end
   end

   // State and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         rnw_q       <= 1'b0;
         dev_q       <= 7'd0;
         reg_q       <= 8'h00;
         wdata_q     <= 8'h00;
         rdata_q     <= 8'h00;
         cnt_q       <= {CW{1'b0}};
         phase_q     <= 1'b0;
         cyc_q       <= 1'b0;
         sel_q       <= 4'b0000;
         adr_q       <= 32'h0000_0000;
         dat_q       <= 16'h0000;
         we_q        <= 1'b0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_err_q   <= 2'd0;
      end else begin
         state_q     <= state_d;
         rnw_q       <= rnw_d;
         dev_q       <= dev_d;
         reg_q       <= reg_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         cyc_q       <= cyc_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         we_q        <= we_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign req_ready = ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;
   assign m_adr_o   = adr_q;
   assign m_dat_o   = {16'h0000, dat_q};
   assign m_sel_o   = sel_q;
   assign m_we_o    = we_q;
   assign m_cyc_o   = cyc_q;
   assign m_stb_o   = cyc_q;
endmodule

// File: tb/tb_i2c_reg_xfer_seq.sv
// Directed bench for i2c_reg_xfer_seq: a small EF_I2C slave model answers the Wishbone port,
// and expected bus accesses and responses are queued then checked as the DUT produces them.
module tb_i2c_reg_xfer_seq;
   localparam logic [31:0] BASE_C = 32'h3000_0000;
   localparam logic [15:0] ST_C   = 16'h0000;
   localparam logic [15:0] CM_C   = 16'h0004;
   localparam logic [15:0] DA_C   = 16'h0006;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req_valid, req_ready, req_rnw;
   logic [6:0]  req_dev;
   logic [7:0]  req_reg, req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic [1:0]  rsp_err;
   logic [31:0] m_adr_o, m_dat_o, m_dat_i;
   logic [3:0]  m_sel_o;
   logic        m_we_o, m_cyc_o, m_stb_o, m_ack_i;

   always #5 clk_i = ~clk_i;

   i2c_reg_xfer_seq #(
      .BASE(BASE_C), .STATUS_OFF(ST_C), .CMD_OFF(CM_C), .DATA_OFF(DA_C), .POLL_LIMIT(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
      .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
      .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_ack_i(m_ack_i)
   );

   // Slave model configuration (driven by the stimulus)
   int          ack_dly, data_valid_at, stat_busy_n;
   logic [31:0] stat_final, data_val;
   logic        slv_clr;

   int          wait_cnt = 0, data_rd_cnt = 0, stat_rd_cnt = 0;
   logic        ack_r = 1'b0;
   logic [31:0] rd_r = 32'h0;
   assign m_ack_i = ack_r;
   assign m_dat_i = rd_r;

   // EF_I2C slave model: acks after ack_dly wait cycles, DATA valid from read number data_valid_at
   always @(posedge clk_i) begin
      if (slv_clr) begin
         ack_r <= 1'b0; wait_cnt <= 0; data_rd_cnt <= 0; stat_rd_cnt <= 0;
      end else if (ack_r) begin
         ack_r <= 1'b0;
      end else if (m_cyc_o && m_stb_o) begin
         if (wait_cnt >= ack_dly) begin
            ack_r    <= 1'b1;
            wait_cnt <= 0;
            if (m_we_o) begin
               rd_r <= 32'h0;
            end else if (m_adr_o == BASE_C + 32'h6) begin
               data_rd_cnt <= data_rd_cnt + 1;
               rd_r <= (data_rd_cnt + 1 >= data_valid_at) ? data_val : 32'h0000_00EE;
            end else begin
               stat_rd_cnt <= stat_rd_cnt + 1;
               rd_r <= (stat_rd_cnt < stat_busy_n) ? 32'h0000_0001 : stat_final;
            end
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end
   end

   int          errors = 0, checks = 0, rsp_seen = 0;
   logic [68:0] acc_q[$];
   logic [9:0]  rsp_q[$];
   logic        prev_ack = 1'b0, prev_cyc = 1'b0, prev_rsp = 1'b0, p_we = 1'b0;
   logic [31:0] p_adr = 32'h0, p_dat = 32'h0;

   task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic exp_acc(input logic we, input logic [15:0] off, input logic [15:0] dat);
      acc_q.push_back({we, BASE_C + {16'h0000, off}, {16'h0000, dat}, 4'b0011});
   endtask

   task automatic exp_rsp(input logic [7:0] rdata, input logic [1:0] err);
      rsp_q.push_back({rdata, err});
   endtask

   // One clock: sample at the falling edge and run all bus/response monitors
   task automatic step();
      logic [68:0] e_acc;
      logic [9:0]  e_rsp;
      @(negedge clk_i);
      chk("stb_eq_cyc", 69'(m_stb_o), 69'(m_cyc_o));
      if (prev_ack) chk("gap_after_ack", 69'(m_cyc_o), 69'(1'b0));
      if (prev_cyc && m_cyc_o && !prev_ack)
         chk("stable_during_cycle", {m_we_o, m_adr_o, m_dat_o, 4'h0}, {p_we, p_adr, p_dat, 4'h0});
      if (m_cyc_o && m_ack_i) begin
         chk("access_expected", 69'(acc_q.size() != 0), 69'(1'b1));
         if (acc_q.size() != 0) begin
            e_acc = acc_q.pop_front();
            chk("wb_access", {m_we_o, m_adr_o, m_dat_o, m_sel_o}, e_acc);
         end
      end
      if (rsp_valid) begin
         chk("rsp_expected", 69'(rsp_q.size() != 0), 69'(1'b1));
         if (rsp_q.size() != 0) begin
            e_rsp = rsp_q.pop_front();
            chk("rsp_rdata_err", 69'({rsp_rdata, rsp_err}), 69'(e_rsp));
         end
         rsp_seen++;
      end
      if (prev_rsp) begin
         chk("rsp_one_cycle", 69'(rsp_valid), 69'(1'b0));
         chk("ready_after_rsp", 69'(req_ready), 69'(1'b1));
      end
      prev_ack = m_cyc_o && m_ack_i;
      prev_cyc = m_cyc_o;
      p_adr    = m_adr_o;
      p_dat    = m_dat_o;
      p_we     = m_we_o;
      prev_rsp = rsp_valid;
   endtask

   task automatic cfg(input int dly, input int dva, input logic [31:0] dval,
                      input int sbn, input logic [31:0] sfin);
      ack_dly = dly; data_valid_at = dva; data_val = dval;
      stat_busy_n = sbn; stat_final = sfin;
      slv_clr = 1'b1;
      step();
      slv_clr = 1'b0;
   endtask

   task automatic run_req(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd, input logic poke);
      int target;
      chk("ready_before_req", 69'(req_ready), 69'(1'b1));
      req_valid = 1'b1; req_rnw = rnw; req_dev = dev; req_reg = rg; req_wdata = wd;
      step();
      req_valid = 1'b0;
      chk("ready_low_after_accept", 69'(req_ready), 69'(1'b0));
      req_dev = 7'h11; req_reg = 8'hEE; req_wdata = 8'h77; req_rnw = ~rnw;
      target = rsp_seen + 1;
      for (int i = 0; i < 600 && rsp_seen < target; i++) begin
         req_valid = poke && (i < 3);
         step();
      end
      req_valid = 1'b0;
      chk("rsp_within_budget", 69'(rsp_seen >= target), 69'(1'b1));
      step();
      chk("all_accesses_seen", 69'(acc_q.size()), 69'd0);
   endtask

   initial begin
      rst_i = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_dev = 7'd0; req_reg = 8'h00; req_wdata = 8'h00;
      ack_dly = 0; data_valid_at = 1000; data_val = 32'h0; stat_busy_n = 0; stat_final = 32'h0;
      slv_clr = 1'b1;
      step(); step();
      chk("rst_ready", 69'(req_ready), 69'(1'b1));
      chk("rst_bus", {m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o[29:0]}, 69'd0);
      chk("rst_rsp", 69'({rsp_valid, rsp_rdata, rsp_err}), 69'd0);
      rst_i = 1'b0; slv_clr = 1'b0;
      step(); step();

      // Write register: status busy once, then idle
      cfg(0, 1000, 32'h0, 1, 32'h0);
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0010);
      exp_acc(1'b1, DA_C, 16'h02A5); exp_acc(1'b1, CM_C, 16'h1950);
      exp_acc(1'b0, ST_C, 16'h0000); exp_acc(1'b0, ST_C, 16'h0000);
      exp_rsp(8'h00, 2'd0);
      run_req(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0);

      // Read register: DATA valid on the third poll read overall
      cfg(0, 2, 32'h0000_013C, 2, 32'h0);
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0203);
      exp_acc(1'b1, CM_C, 16'h0948); exp_acc(1'b1, CM_C, 16'h1348);
      exp_acc(1'b0, DA_C, 16'h0000); exp_acc(1'b0, ST_C, 16'h0000);
      exp_acc(1'b0, DA_C, 16'h0000); exp_acc(1'b0, ST_C, 16'h0000);
      exp_acc(1'b0, ST_C, 16'h0000);
      exp_rsp(8'h3C, 2'd0);
      run_req(1'b1, 7'h48, 8'h03, 8'h99, 1'b0);

      // NACK seen through STATUS while waiting for read data
      cfg(0, 1000, 32'h0, 0, 32'h0000_0008);
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0207);
      exp_acc(1'b1, CM_C, 16'h0921); exp_acc(1'b1, CM_C, 16'h1321);
      exp_acc(1'b0, DA_C, 16'h0000); exp_acc(1'b0, ST_C, 16'h0000);
      exp_rsp(8'h00, 2'd1);
      run_req(1'b1, 7'h21, 8'h07, 8'h00, 1'b0);

      // NACK on a write
      cfg(0, 1000, 32'h0, 0, 32'h0000_0008);
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0022);
      exp_acc(1'b1, DA_C, 16'h025A); exp_acc(1'b1, CM_C, 16'h1950);
      exp_acc(1'b0, ST_C, 16'h0000);
      exp_rsp(8'h00, 2'd1);
      run_req(1'b0, 7'h50, 8'h22, 8'h5A, 1'b0);

      // Status stuck busy: exactly four status reads, then timeout
      cfg(0, 1000, 32'h0, 1000, 32'h0);
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0001);
      exp_acc(1'b1, DA_C, 16'h02FF); exp_acc(1'b1, CM_C, 16'h1912);
      for (int i = 0; i < 4; i++) exp_acc(1'b0, ST_C, 16'h0000);
      exp_rsp(8'h00, 2'd2);
      run_req(1'b0, 7'h12, 8'h01, 8'hFF, 1'b0);

      // Idle status arrives on the last allowed poll: no timeout
      cfg(0, 1000, 32'h0, 3, 32'h0);
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0001);
      exp_acc(1'b1, DA_C, 16'h02FF); exp_acc(1'b1, CM_C, 16'h1912);
      for (int i = 0; i < 4; i++) exp_acc(1'b0, ST_C, 16'h0000);
      exp_rsp(8'h00, 2'd0);
      run_req(1'b0, 7'h12, 8'h01, 8'hFF, 1'b0);

      // Read data never valid, slave busy: timeout after four alternating polls, rdata 0
      cfg(0, 1000, 32'h0, 1000, 32'h0);
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0203);
      exp_acc(1'b1, CM_C, 16'h0948); exp_acc(1'b1, CM_C, 16'h1348);
      for (int i = 0; i < 2; i++) begin
         exp_acc(1'b0, DA_C, 16'h0000); exp_acc(1'b0, ST_C, 16'h0000);
      end
      exp_rsp(8'h00, 2'd2);
      run_req(1'b1, 7'h48, 8'h03, 8'h00, 1'b0);

      // NACK on the same poll that reaches the limit wins over timeout
      cfg(0, 1000, 32'h0, 1, 32'h0000_0008);
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0203);
      exp_acc(1'b1, CM_C, 16'h0948); exp_acc(1'b1, CM_C, 16'h1348);
      for (int i = 0; i < 2; i++) begin
         exp_acc(1'b0, DA_C, 16'h0000); exp_acc(1'b0, ST_C, 16'h0000);
      end
      exp_rsp(8'h00, 2'd1);
      run_req(1'b1, 7'h48, 8'h03, 8'h00, 1'b0);

      // Slow slave (5 wait cycles per access) plus requests poked while busy
      cfg(5, 1000, 32'h0, 1, 32'h0);
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0010);
      exp_acc(1'b1, DA_C, 16'h02A5); exp_acc(1'b1, CM_C, 16'h1950);
      exp_acc(1'b0, ST_C, 16'h0000); exp_acc(1'b0, ST_C, 16'h0000);
      exp_rsp(8'h00, 2'd0);
      run_req(1'b0, 7'h50, 8'h10, 8'hA5, 1'b1);

      // Asynchronous reset while polling read data
      cfg(0, 1000, 32'h0, 1000, 32'h0);
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0203);
      exp_acc(1'b1, CM_C, 16'h0948); exp_acc(1'b1, CM_C, 16'h1348);
      exp_acc(1'b0, DA_C, 16'h0000);
      req_valid = 1'b1; req_rnw = 1'b1; req_dev = 7'h48; req_reg = 8'h03;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < 200 && acc_q.size() != 0; i++) step();
      chk("reached_pdata", 69'(acc_q.size()), 69'd0);
      #2 rst_i = 1'b1;
      #1;
      chk("async_rst_bus", 69'({m_cyc_o, m_stb_o, rsp_valid}), 69'd0);
      chk("async_rst_ready", 69'(req_ready), 69'(1'b1));
      acc_q.delete();
      rsp_q.delete();
      cfg(0, 1000, 32'h0, 1, 32'h0);
      step();
      rst_i = 1'b0;
      step();
      exp_acc(1'b1, ST_C, 16'h0008); exp_acc(1'b1, DA_C, 16'h0010);
      exp_acc(1'b1, DA_C, 16'h02A5); exp_acc(1'b1, CM_C, 16'h1950);
      exp_acc(1'b0, ST_C, 16'h0000); exp_acc(1'b0, ST_C, 16'h0000);
      exp_rsp(8'h00, 2'd0);
      run_req(1'b0, 7'h50, 8'h10, 8'hA5, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
